// File: rtl/des_key_pkg.sv
// Shared types and constants for the DES key scheduler: FSM states,
// key width, default settle latency and the key-table entry layout.
package des_key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN
  } state_e;

  localparam int unsigned DES_SETTLE = 17;
  localparam int unsigned KEY_W      = 64;

  typedef struct packed {
    logic             mode;
    logic [KEY_W-1:0] key;
  } key_entry_t;

endpackage

// File: rtl/des_key_sched_if.sv
// Host-config and DES-core signal bundle for des_key_sched; master drives
// configuration/control, slave is the scheduler.
interface des_key_sched_if
  import des_key_pkg::*;
#(
  parameter int unsigned NKEYS = 4,
  parameter int unsigned ROT_W = 16
);

  logic                     cfg_wr;
  logic [$clog2(NKEYS)-1:0] cfg_idx;
  logic [KEY_W-1:0]         cfg_key;
  logic                     cfg_mode;
  logic [ROT_W-1:0]         rot_period;
  logic                     ctrl_start;
  logic                     boundary;

  logic [KEY_W-1:0]         key_in;
  logic                     mode_in;
  logic                     key_en;
  logic                     des_hold;
  logic [$clog2(NKEYS)-1:0] active_idx;
  logic                     key_loaded;
  logic [31:0]              key_switch_cnt;

  modport master (
    output cfg_wr, cfg_idx, cfg_key, cfg_mode, rot_period, ctrl_start, boundary,
    input  key_in, mode_in, key_en, des_hold, active_idx, key_loaded, key_switch_cnt
  );

  modport slave (
    input  cfg_wr, cfg_idx, cfg_key, cfg_mode, rot_period, ctrl_start, boundary,
    output key_in, mode_in, key_en, des_hold, active_idx, key_loaded, key_switch_cnt
  );

endinterface

// File: rtl/des_key_table.sv
// NKEYS x {mode,key} register file, one write port, one read port with
// write-through so a same-cycle write is seen by the read.
module des_key_table
  import des_key_pkg::*;
#(
  parameter int unsigned NKEYS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_i,
  input  logic [$clog2(NKEYS)-1:0] wr_idx_i,
  input  key_entry_t               wr_data_i,
  input  logic [$clog2(NKEYS)-1:0] rd_idx_i,
  output key_entry_t               rd_data_o
);

  key_entry_t mem_q [NKEYS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NKEYS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_o = mem_q[rd_idx_i];
    if (wr_i && (wr_idx_i == rd_idx_i)) begin
      rd_data_o = wr_data_i;
    end
  end

endmodule

// File: rtl/des_key_sched.sv
// DES key scheduler: loads table keys into the DES core with a one-cycle
// key_en, stalls the datapath through settle, rotates keys on slice boundaries.
module des_key_sched
  import des_key_pkg::*;
#(
  parameter int unsigned NKEYS  = 4,
  parameter int unsigned ROT_W  = 16,
  parameter int unsigned SETTLE = DES_SETTLE
) (
  input  logic              clk2x,
  input  logic              rst_n_300,
  des_key_sched_if.slave    bus
);

  localparam int unsigned IW = $clog2(NKEYS);
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e           state_q;
  logic [KEY_W-1:0] key_in_q;
  logic             mode_in_q;
  logic             key_en_q;
  logic             des_hold_q;
  logic             key_loaded_q;
  logic [IW-1:0]    active_idx_q;
  logic [31:0]      sw_cnt_q;
  logic [ROT_W-1:0] bnd_cnt_q;
  logic [SW-1:0]    settle_cnt_q;

  logic             rot_hit_d;
  logic             load_go_d;
  logic [IW-1:0]    next_idx_d;
  key_entry_t       wr_entry;
  key_entry_t       rd_entry;

  // The table is always read at the index a load would use, so the entry is
  // ready on the same edge that enters LOAD.
  always_comb begin
    rot_hit_d  = (state_q == ST_RUN) && bus.boundary && (bus.rot_period != '0) &&
                 (bnd_cnt_q == bus.rot_period - ROT_W'(1));
    load_go_d  = bus.ctrl_start || rot_hit_d;
    next_idx_d = bus.ctrl_start ? '0 : active_idx_q + IW'(1);
  end

  assign wr_entry = '{mode: bus.cfg_mode, key: bus.cfg_key};

  des_key_table #(
    .NKEYS (NKEYS)
  ) u_table (
    .clk       (clk2x),
    .rst_n     (rst_n_300),
    .wr_i      (bus.cfg_wr),
    .wr_idx_i  (bus.cfg_idx),
    .wr_data_i (wr_entry),
    .rd_idx_i  (next_idx_d),
    .rd_data_o (rd_entry)
  );

  always_ff @(posedge clk2x or negedge rst_n_300) begin
    if (!rst_n_300) begin
      state_q      <= ST_IDLE;
      key_in_q     <= '0;
      mode_in_q    <= 1'b0;
      key_en_q     <= 1'b0;
      des_hold_q   <= 1'b0;
      key_loaded_q <= 1'b0;
      active_idx_q <= '0;
      sw_cnt_q     <= '0;
      bnd_cnt_q    <= '0;
      settle_cnt_q <= '0;
    end else begin
      key_en_q <= 1'b0;
      if (load_go_d) begin
        state_q      <= ST_LOAD;
        key_in_q     <= rd_entry.key;
        mode_in_q    <= rd_entry.mode;
        active_idx_q <= next_idx_d;
        key_en_q     <= 1'b1;
        des_hold_q   <= 1'b1;
        key_loaded_q <= 1'b0;
        sw_cnt_q     <= sw_cnt_q + 32'd1;
      end else begin
        unique case (state_q)
          ST_IDLE: ;
          ST_LOAD: begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= '0;
          end
          ST_SETTLE: begin
            if (settle_cnt_q == SW'(SETTLE - 1)) begin
              state_q      <= ST_RUN;
              des_hold_q   <= 1'b0;
              key_loaded_q <= 1'b1;
              bnd_cnt_q    <= '0;
            end else begin
              settle_cnt_q <= settle_cnt_q + SW'(1);
            end
          end
          ST_RUN: begin
            if (bus.boundary) begin
              bnd_cnt_q <= bnd_cnt_q + ROT_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.key_in         = key_in_q;
  assign bus.mode_in        = mode_in_q;
  assign bus.key_en         = key_en_q;
  assign bus.des_hold       = des_hold_q;
  assign bus.active_idx     = active_idx_q;
  assign bus.key_loaded     = key_loaded_q;
  assign bus.key_switch_cnt = sw_cnt_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Self-checking bench for des_key_sched: random table contents, a scoreboard
// of expected loads derived from the rotation rules, and timing checks.
module tb_des_key_sched;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  des_key_sched_if #(.NKEYS(4), .ROT_W(16)) bus ();

  des_key_sched #(
    .NKEYS  (4),
    .ROT_W  (16),
    .SETTLE (17)
  ) dut (
    .clk2x     (clk),
    .rst_n_300 (rst_n),
    .bus       (bus)
  );

  int checks   = 0;
  int failures = 0;
  int exp_sw   = 0;

  logic [63:0] mk [4];
  logic        mm [4];

  int          log_idx [$];
  logic [63:0] log_key [$];
  logic        log_mode[$];
  int          exp_idx [$];

  always @(negedge clk) begin
    if (bus.key_en === 1'b1) begin
      log_idx.push_back(int'(bus.active_idx));
      log_key.push_back(bus.key_in);
      log_mode.push_back(bus.mode_in);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_idx.delete();
    log_key.delete();
    log_mode.delete();
  endtask

  task automatic write_slot(input int idx, input logic [63:0] k, input logic m);
    bus.cfg_wr   = 1'b1;
    bus.cfg_idx  = idx[1:0];
    bus.cfg_key  = k;
    bus.cfg_mode = m;
    tick();
    bus.cfg_wr   = 1'b0;
    mk[idx] = k;
    mm[idx] = m;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4; i++) begin
      write_slot(i, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic start_pulse();
    bus.ctrl_start = 1'b1;
    tick();
    bus.ctrl_start = 1'b0;
    exp_sw++;
  endtask

  task automatic bnd_pulse();
    bus.boundary = 1'b1;
    tick();
    bus.boundary = 1'b0;
  endtask

  task automatic wait_run(input string name);
    int n = 0;
    while (bus.key_loaded !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (bus.key_loaded !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout key_loaded=%b required=1", name, bus.key_loaded);
    end
  endtask

  // Pure rule-level model: a counter of RUN boundaries per key, advancing the
  // slot modulo 4 each time rp boundaries have been seen.
  task automatic model_rotation(input int rp, input int n, input int start_idx);
    int cnt = 0;
    int idx = start_idx;
    exp_idx.delete();
    for (int i = 0; i < n; i++) begin
      if (rp != 0 && cnt == rp - 1) begin
        idx = (idx + 1) % 4;
        exp_idx.push_back(idx);
        cnt = 0;
      end else begin
        cnt++;
      end
    end
    exp_sw += exp_idx.size();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.key_in !== 64'h0 || bus.mode_in !== 1'b0 || bus.key_en !== 1'b0 ||
        bus.des_hold !== 1'b0 || bus.active_idx !== 2'd0 || bus.key_loaded !== 1'b0 ||
        bus.key_switch_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_values key=%h mode=%b en=%b hold=%b idx=%0d ld=%b cnt=%0d required all zero",
               bus.key_in, bus.mode_in, bus.key_en, bus.des_hold, bus.active_idx,
               bus.key_loaded, bus.key_switch_cnt);
    end
    rst_n = 1'b1;
    tick();
    exp_sw = 0;
    for (int i = 0; i < 4; i++) begin
      mk[i] = '0;
      mm[i] = 1'b0;
    end
  endtask

  task automatic test_basic_load();
    int hold_cnt = 1;
    int en_cnt = 1;
    int k = 0;
    write_slot(0, 64'ha1b2c3d4e5f61234, 1'b0);
    start_pulse();
    checks++;
    if (bus.key_en !== 1'b1 || bus.key_in !== 64'ha1b2c3d4e5f61234 || bus.mode_in !== 1'b0 ||
        bus.des_hold !== 1'b1) begin
      failures++;
      $display("FAIL basic_load en=%b key=%h mode=%b hold=%b required en=1 key=a1b2c3d4e5f61234 mode=0 hold=1",
               bus.key_en, bus.key_in, bus.mode_in, bus.des_hold);
    end
    while (bus.key_loaded !== 1'b1 && k < 40) begin
      tick();
      k++;
      if (bus.des_hold === 1'b1) hold_cnt++;
      if (bus.key_en === 1'b1) en_cnt++;
    end
    checks++;
    if (hold_cnt != 18) begin
      failures++;
      $display("FAIL basic_hold_cycles got=%0d required=18", hold_cnt);
    end
    checks++;
    if (k != 18 || bus.key_loaded !== 1'b1) begin
      failures++;
      $display("FAIL basic_run_latency got=%0d required=18", k);
    end
    checks++;
    if (en_cnt != 1 || bus.key_switch_cnt !== 32'd1) begin
      failures++;
      $display("FAIL basic_key_en_count pulses=%0d cnt=%0d required 1", en_cnt, bus.key_switch_cnt);
    end
  endtask

  task automatic test_rotation();
    fill_random();
    bus.rot_period = 16'd3;
    start_pulse();
    wait_run("rotation_start");
    clear_log();
    model_rotation(3, 8, 0);
    for (int i = 0; i < 8; i++) begin
      bnd_pulse();
      repeat (40) tick();
    end
    checks++;
    if (log_idx.size() != exp_idx.size()) begin
      failures++;
      $display("FAIL rotation_load_count got=%0d required=%0d", log_idx.size(), exp_idx.size());
    end else begin
      for (int i = 0; i < exp_idx.size(); i++) begin
        checks++;
        if (log_idx[i] != exp_idx[i] || log_key[i] !== mk[exp_idx[i]] || log_mode[i] !== mm[exp_idx[i]]) begin
          failures++;
          $display("FAIL rotation_load%0d idx=%0d key=%h mode=%b required idx=%0d key=%h mode=%b",
                   i, log_idx[i], log_key[i], log_mode[i], exp_idx[i], mk[exp_idx[i]], mm[exp_idx[i]]);
        end
      end
    end
    checks++;
    if (bus.active_idx !== 2'd2 || bus.key_switch_cnt !== 32'(exp_sw)) begin
      failures++;
      $display("FAIL rotation_final idx=%0d cnt=%0d required idx=2 cnt=%0d",
               bus.active_idx, bus.key_switch_cnt, exp_sw);
    end
  endtask

  task automatic test_wrap();
    bus.rot_period = 16'd1;
    clear_log();
    start_pulse();
    wait_run("wrap_start");
    model_rotation(1, 5, 0);
    exp_idx.push_front(0);
    for (int i = 0; i < 5; i++) begin
      bnd_pulse();
      repeat (25) tick();
    end
    checks++;
    if (log_idx.size() != 6) begin
      failures++;
      $display("FAIL wrap_load_count got=%0d required=6", log_idx.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (log_idx[i] != exp_idx[i] || log_key[i] !== mk[exp_idx[i]]) begin
          failures++;
          $display("FAIL wrap_load%0d idx=%0d key=%h required idx=%0d key=%h",
                   i, log_idx[i], log_key[i], exp_idx[i], mk[exp_idx[i]]);
        end
      end
    end
  endtask

  task automatic test_dropped_boundaries();
    fill_random();
    bus.rot_period = 16'd2;
    start_pulse();
    repeat (3) tick();
    bnd_pulse();
    tick();
    bnd_pulse();
    wait_run("dropped_start");
    clear_log();
    bnd_pulse();
    repeat (5) tick();
    checks++;
    if (log_idx.size() != 0) begin
      failures++;
      $display("FAIL dropped_early_load loads=%0d required=0", log_idx.size());
    end
    bnd_pulse();
    repeat (3) tick();
    exp_sw++;
    checks++;
    if (log_idx.size() != 1 || log_idx[0] != 1 || log_key[0] !== mk[1] || log_mode[0] !== mm[1]) begin
      failures++;
      $display("FAIL dropped_rotation loads=%0d idx=%0d required loads=1 idx=1 key=%h",
               log_idx.size(), (log_idx.size() > 0) ? log_idx[0] : -1, mk[1]);
    end
    wait_run("dropped_rot");
  endtask

  task automatic test_bypass_priority();
    logic [63:0] nk;
    nk = {$urandom, $urandom};
    bus.cfg_wr     = 1'b1;
    bus.cfg_idx    = 2'd0;
    bus.cfg_key    = nk;
    bus.cfg_mode   = 1'b1;
    bus.ctrl_start = 1'b1;
    tick();
    bus.cfg_wr     = 1'b0;
    bus.ctrl_start = 1'b0;
    mk[0] = nk;
    mm[0] = 1'b1;
    exp_sw++;
    checks++;
    if (bus.key_en !== 1'b1 || bus.key_in !== nk || bus.mode_in !== 1'b1 || bus.active_idx !== 2'd0) begin
      failures++;
      $display("FAIL bypass_load en=%b key=%h mode=%b idx=%0d required en=1 key=%h mode=1 idx=0",
               bus.key_en, bus.key_in, bus.mode_in, bus.active_idx, nk);
    end
    wait_run("bypass");
    bus.rot_period = 16'd1;
    bnd_pulse();
    exp_sw++;
    wait_run("priority_rot");
    checks++;
    if (bus.active_idx !== 2'd1) begin
      failures++;
      $display("FAIL priority_setup idx=%0d required=1", bus.active_idx);
    end
    bus.boundary   = 1'b1;
    bus.ctrl_start = 1'b1;
    tick();
    bus.boundary   = 1'b0;
    bus.ctrl_start = 1'b0;
    exp_sw++;
    checks++;
    if (bus.key_en !== 1'b1 || bus.active_idx !== 2'd0 || bus.key_in !== mk[0]) begin
      failures++;
      $display("FAIL priority_start en=%b idx=%0d key=%h required en=1 idx=0 key=%h",
               bus.key_en, bus.active_idx, bus.key_in, mk[0]);
    end
    wait_run("priority_start");
    checks++;
    if (bus.key_switch_cnt !== 32'(exp_sw)) begin
      failures++;
      $display("FAIL switch_count got=%0d required=%0d", bus.key_switch_cnt, exp_sw);
    end
  endtask

  task automatic test_reset_mid_settle();
    start_pulse();
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.key_in !== 64'h0 || bus.mode_in !== 1'b0 || bus.key_en !== 1'b0 ||
        bus.des_hold !== 1'b0 || bus.active_idx !== 2'd0 || bus.key_loaded !== 1'b0 ||
        bus.key_switch_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_values key=%h hold=%b idx=%0d cnt=%0d required all zero",
               bus.key_in, bus.des_hold, bus.active_idx, bus.key_switch_cnt);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    exp_sw = 0;
    for (int i = 0; i < 4; i++) begin
      mk[i] = '0;
      mm[i] = 1'b0;
    end
    clear_log();
    repeat (30) tick();
    checks++;
    if (log_idx.size() != 0 || bus.des_hold !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_idle loads=%0d hold=%b required loads=0 hold=0", log_idx.size(), bus.des_hold);
    end
    start_pulse();
    checks++;
    if (bus.key_en !== 1'b1 || bus.key_in !== mk[0] || bus.key_switch_cnt !== 32'(exp_sw)) begin
      failures++;
      $display("FAIL reset_mid_restart en=%b key=%h cnt=%0d required en=1 key=%h cnt=%0d",
               bus.key_en, bus.key_in, bus.key_switch_cnt, mk[0], exp_sw);
    end
    wait_run("reset_mid_restart");
  endtask

  initial begin
    bus.cfg_wr     = 1'b0;
    bus.cfg_idx    = '0;
    bus.cfg_key    = '0;
    bus.cfg_mode   = 1'b0;
    bus.rot_period = '0;
    bus.ctrl_start = 1'b0;
    bus.boundary   = 1'b0;
    rst_n          = 1'b0;
    test_reset();
    test_basic_load();
    test_rotation();
    test_wrap();
    test_dropped_boundaries();
    test_bypass_priority();
    test_reset_mid_settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/des_key_sched.md
# des_key_sched

Key scheduler for the DES stage of the bhargava MPEG scrambler. It holds a small table of DES keys and modes, and loads the selected key into the DES core with a single-cycle `key_en` pulse. After each load it stalls the coefficient datapath until the core's key schedule has settled. While running, it rotates to the next table key after a programmable number of slice boundaries. It sits in the clk2x domain between the host configuration interface and the DES core's `key_in`/`mode_in`/`key_en` inputs.

## Interface
- `NKEYS`, default 4: key table depth; power of two, at least 2.
- `ROT_W`, default 16: width of the rotation period and boundary counter.
- `SETTLE`, default 17: cycles the DES core needs after `key_en` before it accepts data.
- `clk2x`, in, 1: sole clock; everything is on its rising edge.
- `rst_n_300`, in, 1: reset, asynchronous assert, active-low.
- `cfg_wr`, in, 1: write strobe for the key table.
- `cfg_idx`, in, $clog2(NKEYS): table slot written.
- `cfg_key`, in, 64: key written.
- `cfg_mode`, in, 1: mode written (0 = encrypt, 1 = decrypt).
- `rot_period`, in, ROT_W: number of boundaries per key; 0 disables rotation.
- `ctrl_start`, in, 1: pulse; (re)start from slot 0.
- `boundary`, in, 1: pulse from the datapath marking a safe key-switch point (slice end).
- `key_in`, out, 64: key presented to the DES core.
- `mode_in`, out, 1: mode presented to the DES core.
- `key_en`, out, 1: single-cycle load pulse to the DES core.
- `des_hold`, out, 1: datapath stall while a key loads or settles.
- `active_idx`, out, $clog2(NKEYS): slot currently loaded.
- `key_loaded`, out, 1: high in RUN.
- `key_switch_cnt`, out, 32: count of `key_en` pulses, wrapping.

## Operation
- All outputs are registered.
- Reset values: `key_in` = 0, `mode_in` = 0, `key_en` = 0, `des_hold` = 0, `active_idx` = 0, `key_loaded` = 0, `key_switch_cnt` = 0, state IDLE, boundary counter 0, table cleared to zero.
- IDLE:
  - `ctrl_start` → LOAD with next index 0.
  - `boundary` is ignored.
- LOAD (1 cycle):
  - `key_in`/`mode_in` take table[next] and `active_idx` takes next, all on entry to LOAD; they are updated only on entry to LOAD and stay stable until the next LOAD.
  - `key_en` = 1, `des_hold` = 1, `key_switch_cnt` += 1.
  - Next state: SETTLE.
- SETTLE:
  - `des_hold` = 1; the counter runs 0..SETTLE-1.
  - Transition to RUN on the last count; the boundary counter clears to 0.
- RUN:
  - `des_hold` = 0, `key_loaded` = 1.
  - Each `boundary` increments the boundary counter.
  - If `rot_period` != 0 and `boundary` arrives while the counter = `rot_period`-1, go to LOAD with next = (`active_idx`+1) mod NKEYS.
  - If `rot_period` = 0, stay in RUN indefinitely.
- `boundary` pulses in LOAD and SETTLE are dropped and not counted.
- `ctrl_start` in any state forces LOAD with next = 0 on the following cycle, aborting any SETTLE in progress.
- `ctrl_start` has priority over a rotation `boundary` arriving in the same cycle.
- `cfg_wr` is accepted in every state; it never disturbs the currently loaded `key_in`.
- `cfg_wr` to the slot being read on the cycle LOAD is entered: the load uses the new data (write-through bypass).
- `rot_period` is sampled on every comparison. If it is lowered below the current count, rotation occurs at the next counter wrap of ROT_W bits; software must only change it in IDLE.
- Asserting `rst_n_300` mid-operation returns the block to reset values immediately; `key_en` never outputs a partial pulse.

## Timing
- `ctrl_start` at edge T:
  - `key_en` = 1 and `key_in` valid in cycle T+1.
  - `des_hold` = 1 from cycle T+1 through T+1+SETTLE.
  - RUN and `key_loaded` = 1 from cycle T+2+SETTLE.
  - Total stall: SETTLE+1 cycles.
- Rotating `boundary` at edge T: `key_en` in cycle T+1, same stall profile as `ctrl_start`.
- `key_en` is never high for two consecutive cycles except on back-to-back `ctrl_start`.
- A `cfg_wr` at edge T is visible to a LOAD entered at T.

## Structure
- Package `des_key_pkg` holds:
  - the state enum (IDLE, LOAD, SETTLE, RUN);
  - the `DES_SETTLE` default of 17;
  - the `KEY_W` = 64 constant.
- Sub-module `des_key_table`: an NKEYS × 65-bit register file with one write port and one read port with write-through bypass; reset clears it.
- The FSM and the counters live in `des_key_sched`.

## Test plan
- Reset then idle:
  - Stimulus: write slot 0 = 64'ha1b2c3d4e5f61234 with mode 0, then `ctrl_start`.
  - Required: exactly one `key_en`, with that key and mode in the same cycle; `des_hold` high for 18 cycles; `key_switch_cnt` = 1.
- Rotation:
  - Stimulus: slots 0..3 distinct, `rot_period` = 3, 8 `boundary` pulses spaced 40 cycles apart.
  - Required: loads slot 1 after the 3rd pulse and slot 2 after the 6th; `active_idx` sequence 0,1,2.
- Wrap:
  - Stimulus: `rot_period` = 1, 5 boundaries.
  - Required: `active_idx` sequence 0,1,2,3,0,1.
- Dropped boundaries:
  - Stimulus: `boundary` pulses during SETTLE.
  - Required: they are not counted; rotation still waits for `rot_period` pulses counted in RUN.
- Bypass and priority:
  - Stimulus: `cfg_wr` to slot 0 on the cycle `ctrl_start` takes effect.
  - Required: the new key loads.
  - Stimulus: `ctrl_start` together with a rotating boundary.
  - Required: slot 0 loads.
- Reset mid-SETTLE:
  - Stimulus: `rst_n_300` low for 3 cycles in SETTLE.
  - Required: all outputs return to 0 immediately; no `key_en` after release until the next `ctrl_start`.
